// File: rtl/somador_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held in a flop.
// Optional signed-overflow output is enabled by defining SOMADOR_SERIAL_OVF_EN.

module somador_completo_case (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case ({a, b, cin})
      3'b000: begin s = 1'b0; cout = 1'b0; end
      3'b001: begin s = 1'b1; cout = 1'b0; end
      3'b010: begin s = 1'b1; cout = 1'b0; end
      3'b011: begin s = 1'b0; cout = 1'b1; end
      3'b100: begin s = 1'b1; cout = 1'b0; end
      3'b101: begin s = 1'b0; cout = 1'b1; end
      3'b110: begin s = 1'b0; cout = 1'b1; end
      3'b111: begin s = 1'b1; cout = 1'b1; end
      default: begin s = 1'b0; cout = 1'b0; end
    endcase
  end
endmodule

module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] soma,
  output logic             cout
`ifdef SOMADOR_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {OCIOSO, SOMA, PRONTO} estado_t;

  estado_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] soma_q, soma_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_cout;

  somador_completo_case u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // NOTE: every _d gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    s_sh_d      = s_sh_q;
    soma_d      = soma_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef SOMADOR_SERIAL_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SOMA;
        end
      end
      SOMA: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {fa_s, {(WIDTH-1){1'b0}}} | (s_sh_q >> 1);
        carry_d = fa_cout;
        if (cnt_q == CNT_LAST) begin
          // Last bit pair: publish the result instead of letting cnt wrap.
          soma_d      = s_sh_d;
          cout_d      = fa_cout;
          out_valid_d = 1'b1;
          state_d     = PRONTO;
`ifdef SOMADOR_SERIAL_OVF_EN
          ovf_d       = carry_q ^ fa_cout;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRONTO: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= OCIOSO;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      s_sh_q      <= '0;
      soma_q      <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      s_sh_q      <= s_sh_d;
      soma_q      <= soma_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // in_ready is gated by rst_n so it drops immediately while reset is asserted.
  assign in_ready  = rst_n && (state_q == OCIOSO);
  assign out_valid = out_valid_q;
  assign soma      = soma_q;
  assign cout      = cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial (WIDTH=8): directed corner cases plus random
// transactions against an integer-arithmetic reference; ovf checked with SOMADOR_SERIAL_OVF_EN.

module tb_somador_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] soma;
  logic         cout;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  somador_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .soma      (soma),
`ifdef SOMADOR_SERIAL_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic longint ref_unsigned(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    return longint'(x) + longint'(y) + longint'(c);
  endfunction

  function automatic bit ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint sx, sy, s;
    sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    s  = sx + sy + longint'(c);
    return (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int waited = 0;
    while (!in_ready && waited < 4) begin
      step();
      waited++;
    end
    check({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input int stall, input bit noise, input string tag);
    longint exp_full;
    int     lat;
    exp_full = ref_unsigned(ta, tb_v, tc);
    wait_ready(tag);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    step();
    if (noise) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    check({tag, " busy_in_ready"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 2 * W) begin
      step();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(W));
    check({tag, " soma"}, 64'(soma), 64'(exp_full[W-1:0]));
    check({tag, " cout"}, 64'(cout), 64'(exp_full[W]));
`ifdef SOMADOR_SERIAL_OVF_EN
    check({tag, " ovf"}, 64'(ovf), 64'(ref_ovf(ta, tb_v, tc)));
`endif
    check({tag, " excl_in_ready"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold_soma"}, 64'(soma), 64'(exp_full[W-1:0]));
      check({tag, " hold_cout"}, 64'(cout), 64'(exp_full[W]));
      check({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " done_valid"}, 64'(out_valid), 64'd0);
    check({tag, " done_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    step();
    step();
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst soma", 64'(soma), 64'd0);
    check("rst cout", 64'(cout), 64'd0);
`ifdef SOMADOR_SERIAL_OVF_EN
    check("rst ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rel in_ready", 64'(in_ready), 64'd1);

    run_txn(8'h0F, 8'h01, 1'b0, 0, 1'b0, "t1");
    run_txn(8'hFF, 8'h01, 1'b0, 0, 1'b0, "t2a");
    run_txn(8'hFF, 8'hFF, 1'b1, 0, 1'b0, "t2b");
    run_txn(8'h7F, 8'h01, 1'b0, 0, 1'b0, "t3a");
    run_txn(8'h80, 8'h80, 1'b0, 0, 1'b0, "t3b");
    run_txn(8'h05, 8'h03, 1'b0, 0, 1'b0, "t3c");
    run_txn(8'h3C, 8'hA5, 1'b1, 5, 1'b0, "t4");
    run_txn(8'h12, 8'h34, 1'b0, 1, 1'b1, "t5");

    // Reset in the middle of 0xAA+0x55, while bit 3 is being processed.
    wait_ready("t6");
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("t6 in_ready_low", 64'(in_ready), 64'd0);
    step();
    check("t6 out_valid", 64'(out_valid), 64'd0);
    check("t6 soma", 64'(soma), 64'd0);
    check("t6 cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    #1;
    check("t6 rel_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("t6 no_valid", 64'(out_valid), 64'd0);
    end
    run_txn(8'h01, 8'h01, 1'b0, 0, 1'b0, "t6b");

    for (int i = 0; i < 40; i++) begin
      run_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              1'($urandom), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
